seg_capture_decoder: RTL and testbench
======================================

// Module: seg_capture_decoder
// PURPOSE
//  Reverse of the hex-to-7-segment path. Samples a multiplexed, active-low 7-segment bus
//  (one-hot digit strobe + segment pattern) and recovers each digit's hex nibble.
//  Applies a stability filter, then assembles NUM_DIGITS nibbles into one word.
//  Presents the word on a valid/ready handshake for display self-check and readback logic.
// PARAMETERS
//  NUM_DIGITS     4  number of multiplexed digits / nibble slots (>=1)
//  STABLE_CYCLES  4  consecutive matching cycles required before a capture (>=1)
// PORTS
//  clk        in   1             system clock, all logic on rising edge
//  reset      in   1             synchronous, active-high reset
//  seg_n      in   7             segment pattern, active-low, bit0=a .. bit6=g
//  digit_sel  in   NUM_DIGITS    digit strobe, one-hot; bit i selects slot i
//  out_value  out  4*NUM_DIGITS  assembled word; slot i -> out_value[4i+3:4i]
//  out_error  out  1             >=1 slot held an unrecognised pattern; qualified by out_valid
//  out_valid  out  1             word available
//  out_ready  in   1             consumer accepts word when out_valid && out_ready
// BEHAVIOUR
//  Reset: out_value=0, out_error=0, out_valid=0; captured/err flags, s_q, cnt all 0; state COLLECT.
//  Reset mid-operation: partial captures discarded; no word is emitted.
//  Decode table (seg_n hex -> nibble):
//    40->0  79->1  24->2  30->3  19->4  12->5  02->6  78->7
//    00->8  10->9  08->A  03->B  46->C  21->D  06->E  0E->F
//    Any other pattern (incl. 7F blank): nibble 0, slot err flag set.
//  Stability filter (runs every cycle):
//    s_q <= {digit_sel,seg_n}
//    match = ({digit_sel,seg_n}==s_q) && digit_sel one-hot
//    cnt <= match ? min(cnt+1, STABLE_CYCLES) : 0
//    cap = match && (cnt==STABLE_CYCLES-1)
//    -> exactly one cap per stable run; input must be held STABLE_CYCLES+1 cycles
//  Zero or multi-hot digit_sel: no match, cnt cleared, no capture.
//  State COLLECT:
//    cap writes slot i (i = set bit of digit_sel): nibble, err flag, captured[i]=1
//    Re-capture of an already captured slot overwrites it (latest wins).
//    When all captured bits are 1 (including the same-edge write): next cycle HOLD.
//  State HOLD:
//    out_valid=1; out_value/out_error = slot contents, frozen; caps ignored
//    out_error = OR of slot err flags
//    out_valid && out_ready: clear captured and err flags, out_valid=0 next cycle, go COLLECT.
//    The filter keeps running, so a stable run in progress can capture in the first COLLECT cycle.
//  out_value holds its last word after handshake until overwritten. Never assert out_valid
//  without all slots captured since the last handshake/reset.
//  Latency: final capture edge -> out_valid high in following cycle (registered outputs).
//  out_ready may be high before out_valid; it is ignored in COLLECT.
// TESTING (NUM_DIGITS=4, STABLE_CYCLES=4)
//  1. sel=0001/seg=40, 0010/79, 0100/24, 1000/30, each 5 cycles, ready=1
//     -> one out_valid pulse, out_value=16'h3210, out_error=0
//  2. Same as 1 but each digit held only 4 cycles -> no capture, out_valid stays 0
//  3. Slot 2 driven with seg=7F, others valid -> out_valid, out_error=1, nibble 2 = 0
//  4. Word ready, out_ready=0 for 20 cycles while new digits are driven
//     -> out_valid held, out_value unchanged; ready=1 -> accepted, collection restarts
//  5. sel=0011 (multi-hot) or 0000 for 10 cycles -> no capture
//     Slot 0 captured as 8 then re-driven as F -> word shows F in slot 0
//  6. reset pulsed after 3 slots captured -> outputs 0
//     A full 4-slot sequence is then needed before out_valid

Source files
------------

// File: rtl/seg_capture_decoder.sv
// Recovers hex nibbles from a multiplexed active-low 7-segment bus and presents
// the assembled NUM_DIGITS-nibble word on a valid/ready handshake.
module seg_capture_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [4*NUM_DIGITS-1:0] out_value,
   output logic                    out_error,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int SW = NUM_DIGITS + 7;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

   typedef enum logic [0:0] {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   // Returns {err, nibble}; unknown patterns (including blank) decode as 0 with err set.
   function automatic logic [4:0] decode_seg(input logic [6:0] pat);
      case (pat)
         7'h40:   decode_seg = 5'h00;
         7'h79:   decode_seg = 5'h01;
         7'h24:   decode_seg = 5'h02;
         7'h30:   decode_seg = 5'h03;
         7'h19:   decode_seg = 5'h04;
         7'h12:   decode_seg = 5'h05;
         7'h02:   decode_seg = 5'h06;
         7'h78:   decode_seg = 5'h07;
         7'h00:   decode_seg = 5'h08;
         7'h10:   decode_seg = 5'h09;
         7'h08:   decode_seg = 5'h0A;
         7'h03:   decode_seg = 5'h0B;
         7'h46:   decode_seg = 5'h0C;
         7'h21:   decode_seg = 5'h0D;
         7'h06:   decode_seg = 5'h0E;
         7'h0E:   decode_seg = 5'h0F;
         default: decode_seg = 5'h10;
      endcase
   endfunction

   state_t                    state_r;
   logic [SW-1:0]             s_q_r;
   logic [CW-1:0]             cnt_r;
   logic [4*NUM_DIGITS-1:0]   slot_val_r;
   logic [NUM_DIGITS-1:0]     slot_err_r;
   logic [NUM_DIGITS-1:0]     captured_r;

   logic [SW-1:0]             cur_s;
   logic                      onehot_s;
   logic                      match_s;
   logic                      cap_s;
   logic [4:0]                dec_s;
   logic [4*NUM_DIGITS-1:0]   next_val_s;
   logic [NUM_DIGITS-1:0]     next_err_s;
   logic [NUM_DIGITS-1:0]     next_got_s;
   logic                      all_s;

   // Stability match, capture strobe and the slot contents as they would look after a capture.
   always_comb begin
      cur_s    = {digit_sel, seg_n};
      onehot_s = ($countones(digit_sel) == 32'd1);
      match_s  = onehot_s && (cur_s == s_q_r);
      cap_s    = match_s && (cnt_r == CNT_CAP);
      dec_s    = decode_seg(seg_n);
      next_val_s = slot_val_r;
      next_err_s = slot_err_r;
      next_got_s = captured_r;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         next_val_s[4*i +: 4] = (cap_s && digit_sel[i]) ? dec_s[3:0] : slot_val_r[4*i +: 4];
         next_err_s[i]        = (cap_s && digit_sel[i]) ? dec_s[4]   : slot_err_r[i];
         next_got_s[i]        = (cap_s && digit_sel[i]) ? 1'b1       : captured_r[i];
      end
      all_s = &next_got_s;
   end

   // Filter registers, slot storage and the COLLECT/HOLD handshake state machine.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= COLLECT;
         s_q_r      <= '0;
         cnt_r      <= '0;
         slot_val_r <= '0;
         slot_err_r <= '0;
         captured_r <= '0;
         out_value  <= '0;
         out_error  <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         s_q_r <= cur_s;
         cnt_r <= match_s ? ((cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + 1'b1) : '0;
         case (state_r)
            COLLECT: begin
               slot_val_r <= next_val_s;
               slot_err_r <= next_err_s;
               captured_r <= next_got_s;
               if (all_s) begin
                  state_r   <= HOLD;
                  out_valid <= 1'b1;
                  out_value <= next_val_s;
                  out_error <= |next_err_s;
               end else begin
                  state_r   <= COLLECT;
               end
            end
            HOLD: begin
               // Slot values are kept; only the flags restart so a fresh word must be fully re-captured.
               if (out_ready) begin
                  captured_r <= '0;
                  slot_err_r <= '0;
                  out_valid  <= 1'b0;
                  state_r    <= COLLECT;
               end else begin
                  state_r    <= HOLD;
               end
            end
            default: begin
               state_r   <= COLLECT;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Directed plus randomized bench for seg_capture_decoder, checked every cycle
// against a run-length / slot-array reference model.
module tb_seg_capture_decoder;

   localparam int N  = 4;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [6:0]    seg_n;
   logic [N-1:0]  digit_sel;
   logic [4*N-1:0] out_value;
   logic          out_error;
   logic          out_valid;
   logic          out_ready;

   int tests = 0;
   int fails = 0;

   seg_capture_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .reset(reset), .seg_n(seg_n), .digit_sel(digit_sel),
      .out_value(out_value), .out_error(out_error), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model: run length of identical input samples plus an array of slots.
   logic [10:0] m_prev;
   int          m_run;
   bit          m_valid;
   logic [3:0]  m_nib [N];
   bit          m_err [N];
   bit          m_got [N];
   logic [15:0] m_word;
   bit          m_eout;

   logic [15:0] seen_word;
   bit          seen_err;
   int          pulses;
   bit          last_v;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input logic [N-1:0] sel, input logic [6:0] seg, input bit rdy);
      bit cap, found, all;
      int idx;
      logic [3:0] nib;
      if (rst) begin
         m_prev = '0; m_run = 0; m_valid = 0; m_word = '0; m_eout = 0;
         for (int k = 0; k < N; k++) begin m_nib[k] = '0; m_err[k] = 0; m_got[k] = 0; end
         return;
      end
      if ({sel, seg} == m_prev) m_run++; else m_run = 1;
      m_prev = {sel, seg};
      cap = ($countones(sel) == 1) && (m_run == SC + 1);
      if (m_valid) begin
         if (rdy) begin
            m_valid = 0;
            for (int k = 0; k < N; k++) begin m_got[k] = 0; m_err[k] = 0; end
         end
      end else if (cap) begin
         idx = 0;
         for (int k = 0; k < N; k++) if (sel[k]) idx = k;
         found = 0; nib = '0;
         for (int k = 0; k < 16; k++) if (tbl[k] == seg) begin found = 1; nib = k[3:0]; end
         m_nib[idx] = nib; m_err[idx] = !found; m_got[idx] = 1;
         all = 1;
         for (int k = 0; k < N; k++) all = all && m_got[k];
         if (all) begin
            m_valid = 1;
            m_word  = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
            m_eout  = m_err[0] || m_err[1] || m_err[2] || m_err[3];
         end
      end
   endtask

   task automatic cyc(input bit rst, input logic [N-1:0] sel, input logic [6:0] seg, input bit rdy);
      reset = rst; digit_sel = sel; seg_n = seg; out_ready = rdy;
      @(posedge clk);
      model_edge(rst, sel, seg, rdy);
      #1;
      check("valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("value", {16'd0, out_value}, {16'd0, m_word});
      if (m_valid) check("error", {31'd0, out_error}, {31'd0, m_eout});
      if (out_valid) begin seen_word = out_value; seen_err = out_error; end
      if (out_valid && !last_v) pulses++;
      last_v = out_valid;
   endtask

   task automatic hold(input logic [N-1:0] sel, input logic [6:0] seg, input int n, input bit rdy);
      repeat (n) cyc(1'b0, sel, seg, rdy);
   endtask

   initial begin
      int p0, n;
      logic [N-1:0] sel;
      logic [6:0] seg;
      reset = 1'b1; digit_sel = '0; seg_n = 7'h7F; out_ready = 1'b0;
      seen_word = '0; seen_err = 0; pulses = 0; last_v = 0;
      repeat (3) cyc(1'b1, 4'b0000, 7'h7F, 1'b0);
      check("rst_value", {16'd0, out_value}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_error", {31'd0, out_error}, 32'd0);

      // 1: four digits held 5 cycles each
      p0 = pulses;
      hold(4'b0001, 7'h40, 5, 1'b1); hold(4'b0010, 7'h79, 5, 1'b1);
      hold(4'b0100, 7'h24, 5, 1'b1); hold(4'b1000, 7'h30, 5, 1'b1);
      hold(4'b0000, 7'h7F, 3, 1'b1);
      check("t1_pulses", pulses - p0, 32'd1);
      check("t1_word", {16'd0, seen_word}, 32'h3210);
      check("t1_err", {31'd0, seen_err}, 32'd0);

      // 2: held only 4 cycles each
      p0 = pulses;
      hold(4'b0001, 7'h40, 4, 1'b1); hold(4'b0010, 7'h79, 4, 1'b1);
      hold(4'b0100, 7'h24, 4, 1'b1); hold(4'b1000, 7'h30, 4, 1'b1);
      hold(4'b0000, 7'h7F, 3, 1'b1);
      check("t2_pulses", pulses - p0, 32'd0);

      // 3: blank pattern on slot 2
      p0 = pulses;
      hold(4'b0001, 7'h40, 5, 1'b1); hold(4'b0010, 7'h79, 5, 1'b1);
      hold(4'b0100, 7'h7F, 5, 1'b1); hold(4'b1000, 7'h30, 5, 1'b1);
      hold(4'b0000, 7'h7F, 3, 1'b1);
      check("t3_pulses", pulses - p0, 32'd1);
      check("t3_err", {31'd0, seen_err}, 32'd1);
      check("t3_nib2", {28'd0, seen_word[11:8]}, 32'd0);

      // 4: backpressure while new digits are driven
      hold(4'b0001, 7'h19, 5, 1'b0); hold(4'b0010, 7'h12, 5, 1'b0);
      hold(4'b0100, 7'h02, 5, 1'b0); hold(4'b1000, 7'h78, 5, 1'b0);
      hold(4'b0001, 7'h10, 5, 1'b0); hold(4'b0010, 7'h08, 5, 1'b0);
      hold(4'b0100, 7'h03, 5, 1'b0); hold(4'b1000, 7'h46, 5, 1'b0);
      check("t4_held_valid", {31'd0, out_valid}, 32'd1);
      check("t4_held_value", {16'd0, out_value}, 32'h7654);
      hold(4'b0000, 7'h7F, 1, 1'b1);
      check("t4_accepted", {31'd0, out_valid}, 32'd0);
      hold(4'b0000, 7'h7F, 3, 1'b1);

      // 5: multi-hot / zero strobes, then slot 0 overwritten
      p0 = pulses;
      hold(4'b0011, 7'h40, 10, 1'b1); hold(4'b0000, 7'h40, 10, 1'b1);
      check("t5_nocap", pulses - p0, 32'd0);
      hold(4'b0001, 7'h00, 5, 1'b1); hold(4'b0001, 7'h0E, 5, 1'b1);
      hold(4'b0010, 7'h79, 5, 1'b1); hold(4'b0100, 7'h24, 5, 1'b1);
      hold(4'b1000, 7'h30, 5, 1'b1); hold(4'b0000, 7'h7F, 3, 1'b1);
      check("t5_word", {16'd0, seen_word}, 32'h321F);

      // 6: reset after three captures
      hold(4'b0001, 7'h40, 5, 1'b1); hold(4'b0010, 7'h79, 5, 1'b1); hold(4'b0100, 7'h24, 5, 1'b1);
      cyc(1'b1, 4'b0000, 7'h7F, 1'b1); cyc(1'b1, 4'b0000, 7'h7F, 1'b1);
      check("t6_rst_value", {16'd0, out_value}, 32'd0);
      check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      p0 = pulses;
      hold(4'b1000, 7'h30, 5, 1'b1); hold(4'b0000, 7'h7F, 3, 1'b1);
      check("t6_partial", pulses - p0, 32'd0);
      hold(4'b0001, 7'h40, 5, 1'b1); hold(4'b0010, 7'h79, 5, 1'b1);
      hold(4'b0100, 7'h24, 5, 1'b1); hold(4'b1000, 7'h30, 5, 1'b1);
      hold(4'b0000, 7'h7F, 3, 1'b1);
      check("t6_full", pulses - p0, 32'd1);
      check("t6_word", {16'd0, seen_word}, 32'h3210);

      // Random runs with random backpressure and occasional reset
      for (int r = 0; r < 150; r++) begin
         sel = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
         seg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 15)];
         n   = $urandom_range(1, 7);
         for (int c = 0; c < n; c++)
            cyc(($urandom_range(0, 199) == 0), sel, seg, ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
